uart_rx_param: RTL and testbench

//   Parametrised UART receiver, next generation of the team's fixed 8N1 receiver core.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_tick.sv | 30 +++
 rtl/uart_rx_param.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_param.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
// No logic: parity mode codes, FSM state encoding and a 2-of-3 voter.
// Backpressure: not applicable.
package uart_pkg;

    localparam int PAR_NONE      = 0;
    localparam int PAR_EVEN      = 1;
    localparam int PAR_ODD       = 2;
    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-cycle pulse every CLK_DIV clk.
// Latency: first tick CLK_DIV clk after clear; free-running otherwise.
// Backpressure: none, clear restarts the phase.
module uart_baud_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with majority voting and error/break/overrun detection.
// Latency: valid_out rises 2 clk after the clk holding the last stop-bit vote.
// Backpressure: valid_out held until ready_in; a frame completing while held is dropped (overrun_err).
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] T_VOTE    = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] T_LAST    = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

    rx_state_e state, state_nxt;

    logic                 rx_meta, rx_s;
    logic [1:0]           samp;
    logic                 tick, div_clear;
    logic [TW-1:0]        tcnt;
    logic [3:0]           bcnt;
    logic [DATA_BITS-1:0] sh;
    logic                 par_bit, par_err_p, frm_err_p, stop_one;
    logic                 done, done_brk, done_perr, done_ferr;
    logic                 vote, vote_tick, start_edge, last_data, last_stop, brk_now, par_exp;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    uart_baud_tick #(.CLK_DIV(CLK_DIV)) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (div_clear),
        .tick  (tick)
    );

    // samp holds the two previous ticks; rx_s is the third sample at the vote tick
    always_ff @(posedge clk) begin
        if (rst) begin
            samp <= 2'b11;
        end else if (tick) begin
            samp <= {samp[0], rx_s};
        end
    end

    assign vote       = maj3(samp[1], samp[0], rx_s);
    assign vote_tick  = tick && (tcnt == T_VOTE);
    assign start_edge = (state == ST_IDLE) && ena && !rx_s;
    assign last_data  = (bcnt == LAST_DATA);
    assign last_stop  = (bcnt == LAST_STOP);
    assign brk_now    = (sh == '0) && !par_bit && !stop_one && !vote;
    assign par_exp    = (PARITY == PAR_EVEN) ? ^sh : ~^sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state != ST_IDLE && !ena) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:      if (start_edge) state_nxt = ST_START;
                ST_START:     if (vote_tick) state_nxt = vote ? ST_IDLE : ST_DATA;
                ST_DATA:      if (vote_tick && last_data)
                                  state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                ST_PARITY:    if (vote_tick) state_nxt = ST_STOP;
                ST_STOP:      if (vote_tick && last_stop)
                                  state_nxt = brk_now ? ST_WAIT_IDLE : ST_IDLE;
                ST_WAIT_IDLE: if (tick && rx_s && tcnt == T_LAST) state_nxt = ST_IDLE;
                default:      state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state != ST_IDLE);
        div_clear = start_edge;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt      <= '0;
            bcnt      <= '0;
            sh        <= '0;
            par_bit   <= 1'b0;
            par_err_p <= 1'b0;
            frm_err_p <= 1'b0;
            stop_one  <= 1'b0;
            done      <= 1'b0;
            done_brk  <= 1'b0;
            done_perr <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tcnt      <= '0;
                    bcnt      <= '0;
                    par_bit   <= 1'b0;
                    par_err_p <= 1'b0;
                    frm_err_p <= 1'b0;
                    stop_one  <= 1'b0;
                end
                // here tcnt counts consecutive high ticks instead of bit phase
                ST_WAIT_IDLE: if (tick) tcnt <= rx_s ? tcnt + 1'b1 : '0;
                default:      if (tick) tcnt <= (tcnt == T_LAST) ? '0 : tcnt + 1'b1;
            endcase
            if (vote_tick) begin
                case (state)
                    ST_DATA: begin
                        sh   <= {vote, sh[DATA_BITS-1:1]};
                        bcnt <= last_data ? 4'd0 : bcnt + 4'd1;
                    end
                    ST_PARITY: begin
                        par_bit   <= vote;
                        par_err_p <= (vote != par_exp);
                    end
                    ST_STOP: begin
                        stop_one  <= stop_one | vote;
                        frm_err_p <= frm_err_p | !vote;
                        bcnt      <= last_stop ? 4'd0 : bcnt + 4'd1;
                        if (last_stop) begin
                            done      <= ena;
                            done_brk  <= brk_now;
                            done_perr <= par_err_p;
                            done_ferr <= frm_err_p | !vote;
                            if (brk_now) tcnt <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out    <= '0;
            valid_out   <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
            if (valid_out && ready_in) valid_out <= 1'b0;
            if (done) begin
                if (done_brk) begin
                    break_det <= 1'b1;
                end else if (!valid_out || ready_in) begin
                    data_out   <= sh;
                    parity_err <= done_perr;
                    frame_err  <= done_ferr;
                    valid_out  <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: an 8N1 instance and an 8E1 instance on separate rx lines.
module tb_uart_rx_param;

    localparam int BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b1;
    logic       rx = 1'b1;
    logic       rx_e = 1'b1;
    logic       ready_in = 1'b1;
    logic [7:0] data_out, data_out_e;
    logic       valid_out, parity_err, frame_err, break_det, overrun_err, busy;
    logic       valid_out_e, parity_err_e, frame_err_e, break_det_e, overrun_err_e, busy_e;

    int n_chk = 0;
    int n_fail = 0;
    int vcnt = 0, vhi = 0, bkcnt = 0, ocnt = 0, vcnt_e = 0;
    int v0, h0, b0, o0, e0;
    logic [7:0] cap_data, cap_data_e;
    logic       cap_pe, cap_fe, cap_pe_e, cap_fe_e;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx), .data_out(data_out), .valid_out(valid_out),
        .ready_in(ready_in), .parity_err(parity_err), .frame_err(frame_err),
        .break_det(break_det), .overrun_err(overrun_err), .busy(busy)
    );

    uart_rx_param #(.CLK_DIV(4), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_e (
        .clk(clk), .rst(rst), .ena(ena), .rx(rx_e), .data_out(data_out_e), .valid_out(valid_out_e),
        .ready_in(ready_in), .parity_err(parity_err_e), .frame_err(frame_err_e),
        .break_det(break_det_e), .overrun_err(overrun_err_e), .busy(busy_e)
    );

    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out) vhi++;
            if (valid_out && ready_in) begin
                vcnt++;
                cap_data = data_out;
                cap_pe   = parity_err;
                cap_fe   = frame_err;
            end
            if (valid_out_e && ready_in) begin
                vcnt_e++;
                cap_data_e = data_out_e;
                cap_pe_e   = parity_err_e;
                cap_fe_e   = frame_err_e;
            end
            if (break_det) bkcnt++;
            if (overrun_err) ocnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic sel, input logic v);
        if (sel) rx_e = v;
        else     rx = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input logic sel, input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (has_par) drive_bit(sel, par);
        drive_bit(sel, stop);
        if (sel) rx_e = 1'b1;
        else     rx = 1'b1;
    endtask

    task automatic snap();
        v0 = vcnt; h0 = vhi; b0 = bkcnt; o0 = ocnt; e0 = vcnt_e;
    endtask

    initial begin
        logic [7:0] partial;
        wait_clks(3);
        check("reset_outputs", 32'({data_out, valid_out, parity_err, frame_err, break_det,
                                    overrun_err, busy}), 32'h0);
        rst = 1'b0;
        wait_clks(BIT_CLKS);

        // plain 8N1 frame
        snap();
        send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("a5_handshakes", 32'(vcnt - v0), 32'd1);
        check("a5_valid_cycles", 32'(vhi - h0), 32'd1);
        check("a5_data", 32'(cap_data), 32'hA5);
        check("a5_flags", 32'({cap_pe, cap_fe}), 32'h0);
        check("a5_busy_after", 32'(busy), 32'h0);

        // 8E1: 0x07 has odd weight, so a 0 parity bit is wrong; 0x03 with 0 is correct
        snap();
        send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("e07_handshakes", 32'(vcnt_e - e0), 32'd1);
        check("e07_data", 32'(cap_data_e), 32'h07);
        check("e07_parity_err", 32'(cap_pe_e), 32'h1);
        check("e07_frame_err", 32'(cap_fe_e), 32'h0);
        send_frame(1'b1, 8'h03, 1'b1, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("e03_data", 32'(cap_data_e), 32'h03);
        check("e03_parity_err", 32'(cap_pe_e), 32'h0);

        // stop bit 0
        snap();
        send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
        wait_clks(BIT_CLKS);
        check("3c_handshakes", 32'(vcnt - v0), 32'd1);
        check("3c_data", 32'(cap_data), 32'h3C);
        check("3c_flags", 32'({cap_pe, cap_fe}), 32'h1);

        // break: 10 bit-times low, then high long enough to leave the wait state
        snap();
        rx = 1'b0;
        wait_clks(10 * BIT_CLKS);
        check("brk_busy_while_low", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("brk_pulses", 32'(bkcnt - b0), 32'd1);
        check("brk_no_valid", 32'(vcnt - v0), 32'd0);
        check("brk_busy_after", 32'(busy), 32'h0);
        send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("brk_then_55", 32'(cap_data), 32'h55);

        // overrun: consumer stalled across two frames
        snap();
        ready_in = 1'b0;
        send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
        send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("ovr_valid_held", 32'(valid_out), 32'h1);
        check("ovr_data_kept", 32'(data_out), 32'h11);
        check("ovr_pulses", 32'(ocnt - o0), 32'd1);
        ready_in = 1'b1;
        wait_clks(1);
        check("ovr_valid_drop", 32'(valid_out), 32'h0);
        check("ovr_accepted", 32'(cap_data), 32'h11);

        // runt low pulse of 4 ticks
        snap();
        rx = 1'b0;
        wait_clks(16);
        check("glitch_busy_during", 32'(busy), 32'h1);
        rx = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("glitch_no_valid", 32'(vcnt - v0 + vhi - h0), 32'd0);
        check("glitch_busy_after", 32'(busy), 32'h0);

        // ena dropped mid-frame
        snap();
        partial = 8'h0F;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, partial[0]);
        drive_bit(1'b0, partial[1]);
        ena = 1'b0;
        wait_clks(1);
        check("ena_abort_idle", 32'(busy), 32'h0);
        for (int i = 2; i < 8; i++) drive_bit(1'b0, partial[i]);
        drive_bit(1'b0, 1'b1);
        ena = 1'b1;
        wait_clks(2 * BIT_CLKS);
        check("ena_abort_no_output", 32'({valid_out, break_det, overrun_err}), 32'h0);
        check("ena_abort_no_hs", 32'(vcnt - v0), 32'd0);

        // reset mid-frame with a pending output
        ready_in = 1'b0;
        send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
        wait_clks(BIT_CLKS);
        check("rst_pending_valid", 32'({valid_out, data_out}), 32'h199);
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b0, 1'b1);
        rst = 1'b1;
        wait_clks(1);
        check("rst_midframe_outputs", 32'({data_out, valid_out, parity_err, frame_err, break_det,
                                           overrun_err, busy}), 32'h0);
        rx = 1'b1;
        ready_in = 1'b1;
        rst = 1'b0;
        wait_clks(BIT_CLKS);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
